// File: rtl/sa_cache_way_array.sv
// sa_cache_way_array: N-way set-associative tag+data storage for the sa_cache datapath.
//
// Holds per-way tag, data line and valid bit for every set behind a valid/ready request
// port. Reads are registered (latency 1) and return every way of one set so the caller
// can compare tags in parallel. A sweep FSM clears all valid bits after reset and on
// a flush request; requests are refused while it runs.
//
// Optional feature: define SA_CACHE_WAY_PARITY_EN to store one parity bit per way over
// {tag, data}. par_inj inverts the stored bit on a write, and rsp_perr flags ways whose
// recomputed parity disagrees. Without the macro rsp_perr is tied to zero and par_inj is
// ignored; the port list is the same in both builds.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush, busy         start an invalidate sweep / sweep in progress
//   req_valid/ready     request handshake; req_we selects write (1) or read (0)
//   req_index, req_way  target set and way (way used by writes only)
//   req_tag, req_data   write payload; par_inj corrupts stored parity
//   rsp_valid           one-cycle pulse per accepted read
//   rsp_vld/tag/data    per-way contents of the last read set (held between reads)
//   rsp_perr            per-way parity error of the last read set
module sa_cache_way_array #(
  parameter int unsigned SETS   = 128,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned DATA_W = 128,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  output logic                    busy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [IDX_W-1:0]        req_index,
  input  logic [WAY_W-1:0]        req_way,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic [DATA_W-1:0]       req_data,
  input  logic                    par_inj,
  output logic                    rsp_valid,
  output logic [WAYS-1:0]         rsp_vld,
  output logic [WAYS*TAG_W-1:0]   rsp_tag,
  output logic [WAYS*DATA_W-1:0]  rsp_data,
  output logic [WAYS-1:0]         rsp_perr
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];

  logic                   rsp_valid_q;
  logic [WAYS-1:0]        rsp_vld_q;
  logic [WAYS*TAG_W-1:0]  rsp_tag_q;
  logic [WAYS*DATA_W-1:0] rsp_data_q;

  logic sweeping;
  logic rd_acc;
  logic wr_acc;

  assign sweeping  = (state_q == StSweep);
  assign busy      = sweeping;
  // A flush in the same cycle as a request wins: the request is refused.
  assign req_ready = (state_q == StIdle) & ~flush;
  assign rd_acc    = req_valid & req_ready & ~req_we;
  assign wr_acc    = req_valid & req_ready & req_we;

  // Sweep control: flush (re)starts from set 0 in any state.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    if (flush) begin
      state_d     = StSweep;
      sweep_cnt_d = '0;
    end else if (sweeping) begin
      if (sweep_cnt_q == IDX_W'(SETS - 1)) begin
        state_d = StIdle;
      end
      sweep_cnt_d = sweep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSweep;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  // Valid bits are deliberately not reset; the post-reset sweep clears them before any
  // request can be accepted.
  always_ff @(posedge clk) begin
    if (sweeping) begin
      valid_q[sweep_cnt_q] <= '0;
    end else if (wr_acc) begin
      valid_q[req_index][req_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      tag_mem[req_index][req_way]  <= req_tag;
      data_mem[req_index][req_way] <= req_data;
    end
  end

  // Read port: capture every way of the addressed set; contents hold until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_vld_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_acc;
      if (rd_acc) begin
        rsp_vld_q <= valid_q[req_index];
        for (int unsigned w = 0; w < WAYS; w++) begin
          rsp_tag_q[w*TAG_W +: TAG_W]    <= tag_mem[req_index][w];
          rsp_data_q[w*DATA_W +: DATA_W] <= data_mem[req_index][w];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_data  = rsp_data_q;

`ifdef SA_CACHE_WAY_PARITY_EN
  logic            par_mem [SETS][WAYS];
  logic [WAYS-1:0] rsp_perr_q;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      par_mem[req_index][req_way] <= (^{req_tag, req_data}) ^ par_inj;
    end
  end

  // Only valid ways can report an error; stale parity in invalid ways is meaningless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_perr_q <= '0;
    end else if (rd_acc) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        rsp_perr_q[w] <= valid_q[req_index][w] &
                         ((^{tag_mem[req_index][w], data_mem[req_index][w]}) !=
                          par_mem[req_index][w]);
      end
    end
  end

  assign rsp_perr = rsp_perr_q;
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign rsp_perr       = '0;
`endif

endmodule

// File: tb/tb_sa_cache_way_array.sv
module tb_sa_cache_way_array;

  localparam int SETS   = 128;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 20;
  localparam int DATA_W = 128;
  localparam int IDX_W  = 7;
  localparam int WAY_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   flush = 1'b0;
  logic                   busy;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic                   req_we = 1'b0;
  logic [IDX_W-1:0]       req_index = '0;
  logic [WAY_W-1:0]       req_way = '0;
  logic [TAG_W-1:0]       req_tag = '0;
  logic [DATA_W-1:0]      req_data = '0;
  logic                   par_inj = 1'b0;
  logic                   rsp_valid;
  logic [WAYS-1:0]        rsp_vld;
  logic [WAYS*TAG_W-1:0]  rsp_tag;
  logic [WAYS*DATA_W-1:0] rsp_data;
  logic [WAYS-1:0]        rsp_perr;

  sa_cache_way_array #(
    .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_index(req_index), .req_way(req_way), .req_tag(req_tag), .req_data(req_data),
    .par_inj(par_inj), .rsp_valid(rsp_valid), .rsp_vld(rsp_vld), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .rsp_perr(rsp_perr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: flat arrays of what each way holds, a countdown of sweep cycles
  // left, and the response each accepted read must produce. A flush or reset invalidates
  // everything at once; no read can observe the set-by-set progress of the sweep.
  bit          mv [SETS][WAYS];
  logic [19:0] mt [SETS][WAYS];
  logic [127:0] md [SETS][WAYS];
  bit          mi [SETS][WAYS];
  int          m_sweep = SETS;
  bit          m_rv = 1'b0;
  bit [3:0]    m_rvld = '0;
  bit [3:0]    m_rperr = '0;
  bit          m_known [WAYS];
  logic [19:0] m_rtag [WAYS];
  logic [127:0] m_rdata [WAYS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sweep = SETS;
      m_rv = 1'b0;
      m_rvld = '0;
      m_rperr = '0;
      for (int w = 0; w < WAYS; w++) begin
        m_known[w] = 1'b1;
        m_rtag[w] = '0;
        m_rdata[w] = '0;
      end
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    end else begin
      bit acc;
      acc = req_valid && (m_sweep == 0) && !flush;
      m_rv = acc && !req_we;
      if (m_rv) begin
        for (int w = 0; w < WAYS; w++) begin
          m_rvld[w] = mv[req_index][w];
          m_known[w] = mv[req_index][w];
          if (mv[req_index][w]) begin
            m_rtag[w] = mt[req_index][w];
            m_rdata[w] = md[req_index][w];
          end
`ifdef SA_CACHE_WAY_PARITY_EN
          m_rperr[w] = mv[req_index][w] && mi[req_index][w];
`else
          m_rperr[w] = 1'b0;
`endif
        end
      end
      if (acc && req_we) begin
        mv[req_index][req_way] = 1'b1;
        mt[req_index][req_way] = req_tag;
        md[req_index][req_way] = req_data;
        mi[req_index][req_way] = par_inj;
      end
      if (flush) begin
        m_sweep = SETS;
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
      end else if (m_sweep > 0) begin
        m_sweep--;
      end
    end
  end

  // Per-cycle compare on the falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 128'(busy), 128'(m_sweep > 0));
      check("req_ready", 128'(req_ready), 128'((m_sweep == 0) && !flush));
      check("rsp_valid", 128'(rsp_valid), 128'(m_rv));
      check("rsp_vld", 128'(rsp_vld), 128'(m_rvld));
      check("rsp_perr", 128'(rsp_perr), 128'(m_rperr));
      for (int w = 0; w < WAYS; w++) begin
        if (m_known[w]) begin
          check($sformatf("rsp_tag[%0d]", w), 128'(rsp_tag[w*TAG_W +: TAG_W]), 128'(m_rtag[w]));
          check($sformatf("rsp_data[%0d]", w), rsp_data[w*DATA_W +: DATA_W], m_rdata[w]);
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; flush = 1'b0; par_inj = 1'b0;
  endtask

  task automatic rd(input int idx);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_index = IDX_W'(idx);
  endtask

  task automatic wr(input int idx, input int way, input logic [19:0] tag,
                    input logic [127:0] data, input bit inj);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_index = IDX_W'(idx);
    req_way = WAY_W'(way); req_tag = tag; req_data = data; par_inj = inj;
  endtask

  // Counts falling edges with busy high; call just after the edge that starts a sweep.
  task automatic count_busy(input string name, input int exp);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check(name, 128'(cnt), 128'(exp));
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && busy; i++) @(negedge clk);
    if (busy) check("wait_idle_timeout", 128'(1), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // 1: reset, sweep length, empty reads
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(1));
    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_rsp_vld", 128'(rsp_vld), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    count_busy("reset_sweep_cycles", 128);
    check("ready_after_sweep", 128'(req_ready), 128'(1));
    rd(0); rd(77); idle();
    check("empty_read_vld", 128'(rsp_vld), 128'(0));

    // 2: write then read the same set on the next cycle
    wr(5, 2, 20'hABCDE, 128'h1234, 1'b0);
    rd(5); idle();
    check("t2_rsp_valid", 128'(rsp_valid), 128'(1));
    check("t2_rsp_vld", 128'(rsp_vld), 128'(4'b0100));
    check("t2_tag_way2", 128'(rsp_tag[2*TAG_W +: TAG_W]), 128'(20'hABCDE));
    check("t2_data_way2", rsp_data[2*DATA_W +: DATA_W], 128'h1234);
    idle();
    check("t2_rsp_valid_drop", 128'(rsp_valid), 128'(0));

    // Directed fill/readback across several sets and ways
    for (int i = 0; i < 16; i++)
      wr(i, i % 4, 20'(i * 3 + 1), {4{32'(i * 32'h01010101)}}, 1'b0);
    for (int i = 0; i < 16; i++) rd(i);
    idle();

    // 3: fill set 9, flush; a read offered with flush must be refused
    for (int w = 0; w < WAYS; w++) wr(9, w, 20'(w + 100), 128'(w + 200), 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_index = 7'd9;
    cnt = 0;
    @(negedge clk);
    if (!req_ready) cnt++;
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
    end
    check("t3_not_ready_cycles", 128'(cnt), 128'(129));
    rd(9); idle();
    check("t3_flushed_vld", 128'(rsp_vld), 128'(0));

    // 4: read accepted the cycle before flush keeps its pre-flush valid bits
    wr(3, 1, 20'h11111, 128'hAA, 1'b0);
    wr(3, 3, 20'h33333, 128'hBB, 1'b0);
    rd(3);
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b0;
    check("t4_rsp_valid", 128'(rsp_valid), 128'(1));
    check("t4_rsp_vld", 128'(rsp_vld), 128'(4'b1010));
    check("t4_tag_way3", 128'(rsp_tag[3*TAG_W +: TAG_W]), 128'(20'h33333));
    idle();
    wait_idle();

    // 5: back-to-back reads, then flush restarted mid-sweep
    wr(1, 0, 20'h00001, 128'h1, 1'b0);
    wr(2, 1, 20'h00002, 128'h2, 1'b0);
    wr(3, 2, 20'h00003, 128'h3, 1'b0);
    rd(1); rd(2);
    check("t5_first_vld", 128'(rsp_vld), 128'(4'b0001));
    rd(3);
    check("t5_second_valid", 128'(rsp_valid), 128'(1));
    check("t5_second_vld", 128'(rsp_vld), 128'(4'b0010));
    idle();
    check("t5_third_valid", 128'(rsp_valid), 128'(1));
    check("t5_third_vld", 128'(rsp_vld), 128'(4'b0100));
    @(posedge clk); #1 flush = 1'b1;
    idle();
    repeat (50) @(posedge clk);
    #1 flush = 1'b1;
    idle();
    count_busy("t5_restart_sweep_cycles", 128);

    // 6: parity injection on way 0
    wr(7, 0, 20'h0F0F0, 128'hDEAD_BEEF, 1'b1);
    wr(7, 1, 20'h12345, 128'hCAFE, 1'b0);
    rd(7); idle();
    check("t6_rsp_vld", 128'(rsp_vld), 128'(4'b0011));
`ifdef SA_CACHE_WAY_PARITY_EN
    check("t6_rsp_perr", 128'(rsp_perr), 128'(4'b0001));
`else
    check("t6_rsp_perr", 128'(rsp_perr), 128'(4'b0000));
`endif

    // Reset during a read response and mid-sweep
    rd(7);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_pre_rsp_valid", 128'(rsp_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    count_busy("rst_mid_sweep_cycles", 128);
    rd(7); idle();
    check("rst_cleared_vld", 128'(rsp_vld), 128'(0));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
